i2c_reg_access: RTL and testbench
=================================

Name: i2c_reg_access

Overview:
- Register-level command front end that sits directly upstream of the team's I2C master engine and drives its start/address/data/length inputs.
- Accepts one register read or write command per valid/ready handshake and builds the engine transfer: register address bytes, then data bytes.
- Waits for the engine to go idle, retries on address NACK, and returns read data plus a status on a valid/ready response channel.

Parameters:
- REG_ADDR_BYTES, 1, register address width in bytes (1..2).
- MAX_DATA_BYTES, 2, maximum data bytes per command.
- MAX_TRANSFER_LENGTH, REG_ADDR_BYTES+MAX_DATA_BYTES, engine transfer size. Must equal the engine's MAX_TRANSFER_LENGTH.
- MAX_RETRIES, 3, extra attempts after an address NACK.
- TIMEOUT_CYCLES, 200000, clk cycles allowed in WAIT before status TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_read  in  1  1 = register read, 0 = register write.
- cmd_dev_addr  in  7  7-bit device address.
- cmd_reg_addr  in  8*REG_ADDR_BYTES  register address, sent MSB byte first.
- cmd_wdata  in  8*MAX_DATA_BYTES  write data; byte 0 ([7:0]) is sent first.
- cmd_len  in  $clog2(MAX_DATA_BYTES+1)  number of data bytes.
- rsp_valid  out  1  response pending.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_status  out  2  0 OK, 1 NACK, 2 TIMEOUT, 3 BAD_LEN.
- rsp_rdata  out  8*MAX_DATA_BYTES  read data; byte 0 = first byte received; unused bytes are 0.
- m_start  out  1  engine start (rising-edge sensitive).
- m_i2c_address  out  7  engine device address.
- m_write_data  out  8*MAX_TRANSFER_LENGTH  engine write data; byte 0 goes out first.
- m_write_transfer_length  out  $clog2(MAX_TRANSFER_LENGTH+1)  engine write length.
- m_read_transfer_length  out  $clog2(MAX_TRANSFER_LENGTH+1)  engine read length.
- m_busy  in  1  engine busy.
- m_no_response  in  1  engine address-NACK flag, valid once busy drops.
- m_total_read  in  $clog2(MAX_TRANSFER_LENGTH+1)  bytes read.
- m_read_data  in  8*MAX_TRANSFER_LENGTH  engine read data; last received byte is in [7:0].

Behaviour:
- Reset (async): state IDLE; cmd_ready=0, rsp_valid=0, rsp_status=0, rsp_rdata=0, m_start=0, all m_* data and length outputs 0, retry and timeout counters 0.
- States: IDLE, ISSUE, GAP, WAIT, EVAL, RESP.
- IDLE
  - cmd_ready = 1 only while m_busy=0 and rsp_valid=0.
  - On accept, latch all cmd fields. If cmd_len==0 or cmd_len>MAX_DATA_BYTES: rsp_status=BAD_LEN, rsp_rdata=0, go to RESP; no engine activity.
  - Otherwise go to ISSUE with retry=0.
- Transfer build (registered, stable from ISSUE until the next accept):
  - m_write_data bytes 0..REG_ADDR_BYTES-1 = reg address, MSB first.
  - Write command: the following bytes carry cmd_wdata bytes 0..len-1. m_write_transfer_length = REG_ADDR_BYTES+len; m_read_transfer_length = 0.
  - Read command: m_write_transfer_length = REG_ADDR_BYTES; m_read_transfer_length = len.
  - Both engine lengths are never 0 together. The engine hangs busy on a zero/zero request, so BAD_LEN filtering is mandatory.
- ISSUE: m_start=1 for exactly one cycle, then GAP.
- GAP: m_start=0 for one cycle. This guarantees a fresh rising edge on a retry. Clear the timeout counter, go to WAIT.
- WAIT
  - Increment the timeout counter each cycle.
  - If m_busy==0, go to EVAL.
  - If the counter reaches TIMEOUT_CYCLES-1, set rsp_status=TIMEOUT and go to RESP. The engine may still be busy; IDLE's m_busy gate blocks new commands until it clears.
- EVAL (one cycle)
  - m_no_response=1: if retry<MAX_RETRIES, increment retry and go to ISSUE; else status NACK, go to RESP.
  - Read with m_total_read!=len: status NACK.
  - Otherwise OK. For a read, rsp_rdata byte i = m_read_data byte (len-1-i) for i<len, and 0 above len.
  - Go to RESP.
- RESP
  - rsp_valid=1, with rsp_status/rsp_rdata held stable until rsp_ready.
  - rsp_valid & rsp_ready in the same cycle: go to IDLE, rsp_valid=0 next cycle.
  - rsp_ready held high before rsp_valid causes no action.
- Latency: a BAD_LEN command gives rsp_valid 2 cycles after accept.
- Reset mid-transfer: outputs return to reset values immediately. The engine is reset separately by the same rst.

Decomposition:
- Package i2c_reg_pkg holds:
  - status codes OK/NACK/TIMEOUT/BAD_LEN;
  - state encoding;
  - a byte-reverse function for the read-data reordering.
- No sub-module: single FSM plus counters. The top-level integration instantiates this block beside the engine.

Test Plan:
- Write dev 0x50, reg 0x12, len 2, wdata 0xBEEF, engine model ACKs all → m_write_data low 3 bytes 0x12,0xEF,0xBE on the wire in order; write length 3, read length 0; rsp OK, rdata 0.
- Read dev 0x50, reg 0x34, len 2; model returns 0xAA then 0x55 (m_read_data=0xAA55, total_read=2) → write length 1, read length 2; rsp OK, rsp_rdata=0x55AA.
- Address NACK on every attempt, MAX_RETRIES=3 → exactly 4 m_start pulses, each separated by a low cycle; rsp NACK.
- NACK on the first attempt, ACK on the second → 2 starts; rsp OK.
- cmd_len=0 and cmd_len=3 → BAD_LEN, m_start never asserted.
- m_busy stuck high, TIMEOUT_CYCLES=50 → TIMEOUT after 50 WAIT cycles; cmd_ready stays 0 until m_busy drops. Also assert rst during WAIT → all outputs 0 in the same cycle.

Source files
------------

// File: rtl/i2c_reg_pkg.sv
// i2c_reg_pkg: response status codes, FSM state encoding and read-data byte reversal
package i2c_reg_pkg;
  typedef enum logic [1:0] {ST_OK, ST_NACK, ST_TIMEOUT, ST_BAD_LEN} status_t;
  typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT, EVAL, RESP} state_t;
  // Reverses the lowest n bytes of d (byte n-1 lands in byte 0); bytes at or above n are 0
  function automatic logic [63:0] byte_rev(logic [63:0] d, int n);
    byte_rev = '0;
    for (int i = 0; i < 8; i++) if (i < n) byte_rev[8*i+:8] = d[8*(n-1-i)+:8];
  endfunction
endpackage

// File: rtl/i2c_reg_access_if.sv
// i2c_reg_access_if: register command request channel and response channel
interface i2c_reg_access_if #(
  parameter int REG_ADDR_BYTES = 1,
  parameter int MAX_DATA_BYTES = 2
);
  import i2c_reg_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_read;
  logic [6:0] cmd_dev_addr;
  logic [8*REG_ADDR_BYTES-1:0] cmd_reg_addr;
  logic [8*MAX_DATA_BYTES-1:0] cmd_wdata;
  logic [$clog2(MAX_DATA_BYTES+1)-1:0] cmd_len;
  logic rsp_valid;
  logic rsp_ready;
  status_t rsp_status;
  logic [8*MAX_DATA_BYTES-1:0] rsp_rdata;
  modport master(
    output cmd_valid, cmd_read, cmd_dev_addr, cmd_reg_addr, cmd_wdata, cmd_len, rsp_ready,
    input cmd_ready, rsp_valid, rsp_status, rsp_rdata
  );
  modport slave(
    input cmd_valid, cmd_read, cmd_dev_addr, cmd_reg_addr, cmd_wdata, cmd_len, rsp_ready,
    output cmd_ready, rsp_valid, rsp_status, rsp_rdata
  );
endinterface

// File: rtl/i2c_reg_access.sv
// i2c_reg_access: turns register read/write commands into I2C engine transfers with NACK retry and timeout
module i2c_reg_access
  import i2c_reg_pkg::*;
#(
  parameter int REG_ADDR_BYTES = 1,
  parameter int MAX_DATA_BYTES = 2,
  parameter int MAX_TRANSFER_LENGTH = REG_ADDR_BYTES + MAX_DATA_BYTES,
  parameter int MAX_RETRIES = 3,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clk,
  input  logic rst,
  i2c_reg_access_if.slave bus,
  output logic m_start,
  output logic [6:0] m_i2c_address,
  output logic [8*MAX_TRANSFER_LENGTH-1:0] m_write_data,
  output logic [$clog2(MAX_TRANSFER_LENGTH+1)-1:0] m_write_transfer_length,
  output logic [$clog2(MAX_TRANSFER_LENGTH+1)-1:0] m_read_transfer_length,
  input  logic m_busy,
  input  logic m_no_response,
  input  logic [$clog2(MAX_TRANSFER_LENGTH+1)-1:0] m_total_read,
  input  logic [8*MAX_TRANSFER_LENGTH-1:0] m_read_data
);
  localparam int LW = $clog2(MAX_DATA_BYTES + 1);
  localparam int TLW = $clog2(MAX_TRANSFER_LENGTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 2);
  state_t state;
  logic rd;
  logic [LW-1:0] len;
  logic [RW-1:0] retry;
  logic [TW-1:0] tcnt;
  logic [8*MAX_TRANSFER_LENGTH-1:0] wd;
  logic [8*MAX_DATA_BYTES-1:0] rev;
  logic bad;
  logic ok;
  // Engine payload for the offered command, length filter, and outcome of the finished transfer
  always_comb begin
    wd = '0;
    for (int j = 0; j < REG_ADDR_BYTES; j++) wd[8*j+:8] = bus.cmd_reg_addr[8*(REG_ADDR_BYTES-1-j)+:8];
    for (int i = 0; i < MAX_DATA_BYTES; i++)
      if (!bus.cmd_read && LW'(i) < bus.cmd_len) wd[8*(REG_ADDR_BYTES+i)+:8] = bus.cmd_wdata[8*i+:8];
    bad = bus.cmd_len == '0 || bus.cmd_len > LW'(MAX_DATA_BYTES);
    ok = !m_no_response && !(rd && m_total_read != TLW'(len));
    rev = (8*MAX_DATA_BYTES)'(byte_rev(64'(m_read_data), int'(len)));
  end
  // Command FSM: accept, pulse start, wait for the engine, retry on NACK, then respond
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd <= 1'b0;
      len <= '0;
      retry <= '0;
      tcnt <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_status <= ST_OK;
      bus.rsp_rdata <= '0;
      m_start <= 1'b0;
      m_i2c_address <= '0;
      m_write_data <= '0;
      m_write_transfer_length <= '0;
      m_read_transfer_length <= '0;
    end else begin
      bus.cmd_ready <= 1'b0;
      m_start <= 1'b0;
      case (state)
        IDLE:
          if (bus.cmd_valid && bus.cmd_ready) begin
            rd <= bus.cmd_read;
            len <= bus.cmd_len;
            if (bad) begin
              bus.rsp_status <= ST_BAD_LEN;
              bus.rsp_rdata <= '0;
              state <= RESP;
            end else begin
              m_i2c_address <= bus.cmd_dev_addr;
              m_write_data <= wd;
              m_write_transfer_length <= TLW'(REG_ADDR_BYTES) + (bus.cmd_read ? TLW'(0) : TLW'(bus.cmd_len));
              m_read_transfer_length <= bus.cmd_read ? TLW'(bus.cmd_len) : TLW'(0);
              retry <= '0;
              m_start <= 1'b1;
              state <= ISSUE;
            end
          end else bus.cmd_ready <= !m_busy;
        ISSUE: state <= GAP;
        GAP: begin
          tcnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (!m_busy) state <= EVAL;
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_status <= ST_TIMEOUT;
            bus.rsp_rdata <= '0;
            state <= RESP;
          end
        end
        EVAL:
          if (m_no_response && retry < RW'(MAX_RETRIES)) begin
            retry <= retry + 1'b1;
            m_start <= 1'b1;
            state <= ISSUE;
          end else begin
            bus.rsp_status <= ok ? ST_OK : ST_NACK;
            bus.rsp_rdata <= ok && rd ? rev : '0;
            state <= RESP;
          end
        RESP: begin
          bus.rsp_valid <= !(bus.rsp_valid && bus.rsp_ready);
          if (bus.rsp_valid && bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access: directed checks of i2c_reg_access against a small I2C engine model
module tb_i2c_reg_access;
  import i2c_reg_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_start, m_busy, m_no_response;
  logic [6:0] m_i2c_address;
  logic [23:0] m_write_data;
  logic [23:0] m_read_data = '0;
  logic [1:0] m_write_transfer_length, m_read_transfer_length;
  logic [1:0] m_total_read = '0;
  int checks = 0;
  int failures = 0;
  int starts, start_hi, cnt;
  int base = 0;
  int nack_n = 0;
  logic stuck = 1'b0;
  logic prev, dbl;
  logic [1:0] st;
  logic [15:0] rdv;
  int lat, hi0, n;
  logic seen;

  i2c_reg_access_if #(.REG_ADDR_BYTES(1), .MAX_DATA_BYTES(2)) bus();

  i2c_reg_access #(
    .REG_ADDR_BYTES(1), .MAX_DATA_BYTES(2), .MAX_TRANSFER_LENGTH(3),
    .MAX_RETRIES(3), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .m_start(m_start), .m_i2c_address(m_i2c_address), .m_write_data(m_write_data),
    .m_write_transfer_length(m_write_transfer_length), .m_read_transfer_length(m_read_transfer_length),
    .m_busy(m_busy), .m_no_response(m_no_response), .m_total_read(m_total_read), .m_read_data(m_read_data)
  );

  always #5 clk = ~clk;

  // Engine model: busy for a few cycles per start edge, NACKs the first nack_n attempts after base
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_busy <= 1'b0; m_no_response <= 1'b0; cnt <= 0;
      starts <= 0; start_hi <= 0; prev <= 1'b0; dbl <= 1'b0;
    end else begin
      prev <= m_start;
      if (m_start) start_hi <= start_hi + 1;
      if (m_start && prev) dbl <= 1'b1;
      if (m_start && !prev) begin
        starts <= starts + 1; m_busy <= 1'b1; cnt <= 3; m_no_response <= 1'b0;
      end else if (m_busy && !stuck) begin
        if (cnt == 0) begin
          m_busy <= 1'b0;
          m_no_response <= (starts - base) <= nack_n;
        end else cnt <= cnt - 1;
      end
    end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(logic rd, logic [6:0] dev, logic [7:0] ra, logic [15:0] wd, logic [1:0] len);
    int k = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_read = rd; bus.cmd_dev_addr = dev;
    bus.cmd_reg_addr = ra; bus.cmd_wdata = wd; bus.cmd_len = len;
    while (!bus.cmd_ready && k < 100) begin @(negedge clk); k++; end
    chk("cmd_accept", 64'(k < 100), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [1:0] s, output logic [15:0] d, output int l);
    l = 0;
    do begin @(negedge clk); l++; end while (!bus.rsp_valid && l < 200);
    chk("rsp_seen", 64'(bus.rsp_valid), 1);
    s = bus.rsp_status; d = bus.rsp_rdata;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", 64'(bus.rsp_valid), 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_dev_addr = '0;
    bus.cmd_reg_addr = '0; bus.cmd_wdata = '0; bus.cmd_len = '0; bus.rsp_ready = 1'b0;
    #3;
    chk("reset_outs", {m_start, m_i2c_address, m_write_data, m_write_transfer_length, m_read_transfer_length,
                       bus.cmd_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_rdata}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(bus.cmd_ready), 1);
    // write dev 0x50 reg 0x12 data 0xBEEF
    base = starts; nack_n = 0;
    send(1'b0, 7'h50, 8'h12, 16'hBEEF, 2'd2);
    chk("wr_wdata", 64'(m_write_data), 64'hBEEF12);
    chk("wr_wlen", 64'(m_write_transfer_length), 3);
    chk("wr_rlen", 64'(m_read_transfer_length), 0);
    chk("wr_addr", 64'(m_i2c_address), 64'h50);
    get_rsp(st, rdv, lat);
    chk("wr_status", 64'(st), 0);
    chk("wr_rdata", 64'(rdv), 0);
    chk("wr_starts", 64'(starts - base), 1);
    // read dev 0x50 reg 0x34 len 2, engine returns AA then 55
    base = starts; m_read_data = 24'h00AA55; m_total_read = 2'd2;
    send(1'b1, 7'h50, 8'h34, 16'h0000, 2'd2);
    chk("rd_wdata", 64'(m_write_data), 64'h34);
    chk("rd_wlen", 64'(m_write_transfer_length), 1);
    chk("rd_rlen", 64'(m_read_transfer_length), 2);
    get_rsp(st, rdv, lat);
    chk("rd_status", 64'(st), 0);
    chk("rd_rdata", 64'(rdv), 64'h55AA);
    // address NACK on every attempt: 1 + 3 retries
    base = starts; hi0 = start_hi; nack_n = 100;
    send(1'b0, 7'h11, 8'h01, 16'h0077, 2'd1);
    get_rsp(st, rdv, lat);
    chk("nack_status", 64'(st), 1);
    chk("nack_starts", 64'(starts - base), 4);
    chk("nack_hi_cycles", 64'(start_hi - hi0), 4);
    chk("nack_no_double", 64'(dbl), 0);
    // NACK once then ACK, single-byte read
    base = starts; nack_n = 1; m_read_data = 24'h00003C; m_total_read = 2'd1;
    send(1'b1, 7'h21, 8'h40, 16'h0000, 2'd1);
    chk("retry_rlen", 64'(m_read_transfer_length), 1);
    get_rsp(st, rdv, lat);
    chk("retry_status", 64'(st), 0);
    chk("retry_starts", 64'(starts - base), 2);
    chk("retry_rdata", 64'(rdv), 64'h3C);
    // short read: total_read 1 for len 2
    base = starts; nack_n = 0;
    send(1'b1, 7'h21, 8'h41, 16'h0000, 2'd2);
    get_rsp(st, rdv, lat);
    chk("short_status", 64'(st), 1);
    chk("short_rdata", 64'(rdv), 0);
    // bad lengths 0 and 3
    base = starts;
    send(1'b0, 7'h50, 8'h12, 16'h1234, 2'd0);
    get_rsp(st, rdv, lat);
    chk("bad0_lat", 64'(lat), 2);
    chk("bad0_status", 64'(st), 3);
    chk("bad0_rdata", 64'(rdv), 0);
    send(1'b1, 7'h50, 8'h12, 16'h1234, 2'd3);
    get_rsp(st, rdv, lat);
    chk("bad3_lat", 64'(lat), 2);
    chk("bad3_status", 64'(st), 3);
    chk("bad_no_start", 64'(starts - base), 0);
    // engine stuck busy -> timeout after 50 WAIT cycles
    stuck = 1'b1;
    send(1'b1, 7'h50, 8'h34, 16'h0000, 2'd2);
    get_rsp(st, rdv, lat);
    chk("to_lat", 64'(lat), 54);
    chk("to_status", 64'(st), 2);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen = seen | bus.cmd_ready; end
    chk("to_ready_low", 64'(seen), 0);
    stuck = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 20);
    chk("to_ready_back", 64'(bus.cmd_ready), 1);
    // reset while waiting on a busy engine
    stuck = 1'b1;
    send(1'b0, 7'h50, 8'h12, 16'h00AB, 2'd1);
    repeat (10) @(negedge clk);
    chk("pre_rst_wlen", 64'(m_write_transfer_length), 2);
    rst = 1'b1;
    #1;
    chk("rst_outs", {m_start, m_i2c_address, m_write_data, m_write_transfer_length, m_read_transfer_length,
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_rdata}, 0);
    stuck = 1'b0;
    @(negedge clk); rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.cmd_ready && n < 20);
    chk("rst_ready_back", 64'(bus.cmd_ready), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
